muldiv_iter: RTL and testbench

Iterative, parametrised RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that replaces the single-cycle combinational multiply/divide in the CPU datapath. The datapath issues one operation over a valid/ready request channel and stalls PC update until the response handshake completes. A multi-cycle shift-add multiplier and a restoring divider share one iteration counter. Divide-by-zero and signed overflow produce the results the ISA defines.

---
 rtl/muldiv_iter.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide sharing one counter.
// Latency: ITER=1 result N=XLEN/ITER_PER_CYCLE clocks after accept; div-by-0/overflow next clock.
// Backpressure: req_ready only in IDLE; result held stable in DONE until rsp_ready (flush kills it).
// Optional: define MULDIV_EARLY_OUT_EN for single-cycle zero-operand / small-dividend shortcuts.
module muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int ITER_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int N  = XLEN / ITER_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]   LAST    = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  // Operation context captured at accept.
  logic [2:0]      op_q;
  logic            neg_q_q;   // product / quotient sign
  logic            neg_r_q;   // remainder sign (dividend sign)
  logic [XLEN:0]   acc_hi_q;  // product high half / partial remainder
  logic [XLEN-1:0] acc_lo_q;  // multiplier, product low half / dividend, quotient
  logic [XLEN-1:0] b_mag_q;   // multiplicand / divisor magnitude
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            in_sgn_a, in_sgn_b, in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_mag, in_b_mag;
  logic            spec_hit;
  logic [XLEN-1:0] spec_data;

  logic [XLEN:0]     step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [XLEN:0]     sum_v, diff_v;
  logic [2*XLEN-1:0] prod_v;
  logic [XLEN-1:0]   quo_v, rem_v, fin_data;

  assign accept = req_valid && req_ready;

  // Operand decode: signedness per funct3, magnitudes, and single-cycle special results.
  always_comb begin
    in_sgn_a  = req_op[2] ? ~req_op[0] : ~(req_op[1] & req_op[0]);
    in_sgn_b  = req_op[2] ? ~req_op[0] : ~req_op[1];
    in_a_neg  = in_sgn_a & req_rs1[XLEN-1];
    in_b_neg  = in_sgn_b & req_rs2[XLEN-1];
    in_a_mag  = in_a_neg ? -req_rs1 : req_rs1;
    in_b_mag  = in_b_neg ? -req_rs2 : req_rs2;
    spec_hit  = 1'b0;
    spec_data = '0;
    if (req_op[2] && (req_rs2 == '0)) begin
      spec_hit  = 1'b1;
      spec_data = req_op[1] ? req_rs1 : '1;
    end else if (req_op[2] && !req_op[0] && (req_rs1 == MIN_NEG) && (req_rs2 == '1)) begin
      spec_hit  = 1'b1;
      spec_data = req_op[1] ? '0 : MIN_NEG;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!req_op[2] && ((req_rs1 == '0) || (req_rs2 == '0))) begin
      spec_hit  = 1'b1;
      spec_data = '0;
    end else if (req_op[2] && (in_a_mag < in_b_mag)) begin
      spec_hit  = 1'b1;
      spec_data = req_op[1] ? req_rs1 : '0;
    end
`endif
  end

  // ITER_PER_CYCLE radix-2 steps: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    sum_v   = '0;
    diff_v  = '0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        step_hi = {step_hi[XLEN-1:0], step_lo[XLEN-1]};
        step_lo = {step_lo[XLEN-2:0], 1'b0};
        diff_v  = step_hi - {1'b0, b_mag_q};
        if (!diff_v[XLEN]) begin
          step_hi    = diff_v;
          step_lo[0] = 1'b1;
        end
      end else begin
        sum_v   = {1'b0, step_hi[XLEN-1:0]} + {1'b0, (step_lo[0] ? b_mag_q : {XLEN{1'b0}})};
        step_lo = {sum_v[0], step_lo[XLEN-1:1]};
        step_hi = {1'b0, sum_v[XLEN:1]};
      end
    end
  end

  // Sign correction and result selection from the final step outputs.
  always_comb begin
    prod_v = {step_hi[XLEN-1:0], step_lo};
    if (neg_q_q) prod_v = -prod_v;
    quo_v = neg_q_q ? -step_lo : step_lo;
    rem_v = neg_r_q ? -step_hi[XLEN-1:0] : step_hi[XLEN-1:0];
    if (op_q[2])
      fin_data = op_q[1] ? rem_v : quo_v;
    else
      fin_data = (op_q[1:0] == 2'b00) ? prod_v[XLEN-1:0] : prod_v[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state and handshake outputs; flush forces IDLE from anywhere.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        req_ready = !flush;
        if (accept) state_d = spec_hit ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath: capture at accept, iterate in CALC, load the result on the last step.
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      op_q     <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_mag_q  <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
    end else if (accept) begin
      op_q     <= req_op;
      neg_q_q  <= in_a_neg ^ in_b_neg;
      neg_r_q  <= in_a_neg;
      acc_hi_q <= '0;
      acc_lo_q <= in_a_mag;
      b_mag_q  <= in_b_mag;
      cnt_q    <= '0;
      rsp_tag  <= req_tag;
      if (spec_hit) rsp_data <= spec_data;
    end else if ((state_q == S_CALC) && !flush) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q + CNT_ONE;
      if (cnt_q == LAST) rsp_data <= fin_data;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: one ITER_PER_CYCLE=1 and one ITER_PER_CYCLE=4 instance.
// Results come from plain 64-bit/integer arithmetic on the ISA rules.
// Latency counts edges including the accept edge (special case = 1, full path = N+1).
module tb_muldiv_iter;

  logic SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  logic SYS_reset_n;
  logic flush;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] req_rs1, req_rs2, rsp_data;
  logic [1:0][4:0]  req_tag, rsp_tag;

  int checks   = 0;
  int failures = 0;

  muldiv_iter #(.XLEN(32), .ITER_PER_CYCLE(1), .TAG_W(5)) u_dut1 (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n), .flush(flush),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_rs1(req_rs1[0]), .req_rs2(req_rs2[0]), .req_tag(req_tag[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_tag(rsp_tag[0]), .busy(busy[0])
  );

  muldiv_iter #(.XLEN(32), .ITER_PER_CYCLE(4), .TAG_W(5)) u_dut4 (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n), .flush(flush),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_rs1(req_rs1[1]), .req_rs2(req_rs2[1]), .req_tag(req_tag[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_tag(rsp_tag[1]), .busy(busy[1])
  );

  task automatic chk_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // ISA reference result.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic longint abs32(input logic [31:0] v);
    int iv;
    longint lv;
    iv = v;
    lv = iv;
    return (lv < 0) ? -lv : lv;
  endfunction

  // Expected latency in edges counted from (and including) the accept edge.
  function automatic int ref_lat(input int u, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (u == 0) ? 32 : 8;
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2] && (a == 0 || b == 0)) return 1;
    if (op[2] && op[0] && a < b) return 1;
    if (op[2] && !op[0] && abs32(a) < abs32(b)) return 1;
`endif
    return n + 1;
  endfunction

  // Present one request and return right after the accept edge (+1); then scramble inputs.
  task automatic start_op(input int u, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
    @(negedge SYS_clk);
    req_valid[u] = 1'b1;
    req_op[u]    = op;
    req_rs1[u]   = a;
    req_rs2[u]   = b;
    req_tag[u]   = tag;
    chk_eq("req_ready_idle", 64'(req_ready[u]), 64'd1);
    @(posedge SYS_clk);
    #1;
    req_valid[u] = 1'b0;
    req_op[u]    = 3'($urandom);
    req_rs1[u]   = $urandom;
    req_rs2[u]   = $urandom;
    req_tag[u]   = ~tag;
  endtask

  task automatic do_op(input int u, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_res(op, a, b);
    rsp_ready[u] = 1'b0;
    start_op(u, op, a, b, tag);
    lat = 1;
    while (!rsp_valid[u] && lat < 200) begin
      @(posedge SYS_clk);
      #1;
      lat++;
    end
    chk_eq("latency", 64'(lat), 64'(ref_lat(u, op, a, b)));
    chk_eq("rsp_data", 64'(rsp_data[u]), 64'(exp));
    chk_eq("rsp_tag", 64'(rsp_tag[u]), 64'(tag));
    chk_eq("busy_done", 64'(busy[u]), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge SYS_clk);
      #1;
      chk_eq("hold_valid", 64'(rsp_valid[u]), 64'd1);
      chk_eq("hold_data", 64'(rsp_data[u]), 64'(exp));
      chk_eq("hold_tag", 64'(rsp_tag[u]), 64'(tag));
      chk_eq("hold_req_ready", 64'(req_ready[u]), 64'd0);
    end
    @(negedge SYS_clk);
    rsp_ready[u] = 1'b1;
    @(posedge SYS_clk);
    #1;
    chk_eq("post_rsp_valid", 64'(rsp_valid[u]), 64'd0);
    chk_eq("post_req_ready", 64'(req_ready[u]), 64'd1);
    rsp_ready[u] = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  int vld_seen;

  initial begin
    SYS_reset_n = 1'b0;
    flush       = 1'b0;
    req_valid   = '0;
    req_op      = '0;
    req_rs1     = '0;
    req_rs2     = '0;
    req_tag     = '0;
    rsp_ready   = '0;
    #12;
    for (int u = 0; u < 2; u++) begin
      chk_eq("rst_req_ready", 64'(req_ready[u]), 64'd1);
      chk_eq("rst_rsp_valid", 64'(rsp_valid[u]), 64'd0);
      chk_eq("rst_rsp_data", 64'(rsp_data[u]), 64'd0);
      chk_eq("rst_rsp_tag", 64'(rsp_tag[u]), 64'd0);
      chk_eq("rst_busy", 64'(busy[u]), 64'd0);
    end
    @(negedge SYS_clk);
    SYS_reset_n = 1'b1;

    // Directed cases on the ITER_PER_CYCLE=1 instance.
    do_op(0, 3'b000, 32'd7, -32'd3, 5'd9, 0);
    do_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    do_op(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    do_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 5);
    do_op(0, 3'b100, -32'd7, 32'd2, 5'd4, 0);
    do_op(0, 3'b110, -32'd7, 32'd2, 5'd5, 0);
    do_op(0, 3'b101, 32'd100, 32'd0, 5'd6, 0);
    do_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 2);
    do_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    do_op(0, 3'b111, 32'h1234, 32'd0, 5'd10, 0);

    // Early-out candidates on the ITER_PER_CYCLE=4 instance.
    do_op(1, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd11, 0);
    do_op(1, 3'b101, 32'd3, 32'd10, 5'd12, 0);
    do_op(1, 3'b110, -32'd3, 32'd10, 5'd13, 0);

    // Flush mid-divide with a simultaneous request.
    start_op(0, 3'b100, 32'd1000, 32'd7, 5'd14);
    repeat (9) @(posedge SYS_clk);
    @(negedge SYS_clk);
    flush        = 1'b1;
    req_valid[0] = 1'b1;
    req_op[0]    = 3'b000;
    req_rs1[0]   = 32'd5;
    req_rs2[0]   = 32'd6;
    rsp_ready[0] = 1'b1;
    @(posedge SYS_clk);
    #1;
    chk_eq("flush_busy", 64'(busy[0]), 64'd0);
    chk_eq("flush_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    flush        = 1'b0;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    #1;
    chk_eq("flush_req_ready", 64'(req_ready[0]), 64'd1);
    vld_seen = 0;
    repeat (40) begin
      @(negedge SYS_clk);
      if (rsp_valid[0] || busy[0]) vld_seen++;
    end
    chk_eq("flush_no_rsp", 64'(vld_seen), 64'd0);

    // Randomized traffic on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 30; k++) begin
        do_op(u, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
              5'($urandom), $urandom_range(0, 2));
      end
    end

    // Reset pulse during CALC, after a nonzero result and tag were presented.
    do_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 0);
    start_op(0, 3'b101, 32'd99999, 32'd13, 5'd22);
    repeat (5) @(posedge SYS_clk);
    #2;
    SYS_reset_n = 1'b0;
    #1;
    chk_eq("mid_rst_req_ready", 64'(req_ready[0]), 64'd1);
    chk_eq("mid_rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk_eq("mid_rst_rsp_data", 64'(rsp_data[0]), 64'd0);
    chk_eq("mid_rst_rsp_tag", 64'(rsp_tag[0]), 64'd0);
    chk_eq("mid_rst_busy", 64'(busy[0]), 64'd0);
    @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    do_op(0, 3'b100, -32'd100, 32'd7, 5'd23, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
